// File: rtl/feedback_enable_sequencer.sv
// feedback_enable_sequencer
// Upstream control stage for the loop-feedback enable path. It raises
// enable_feedback on a start request and waits for the feedback cell to report ok.
// Once ok is seen, it holds the enable for a programmed time and then reports done.
// If ok does not arrive in time, it cools down and retries.
// When the retries are exhausted, or on abort, it reports fail.
// Optional feature macro: FBSEQ_OK_SYNC_EN
//   defined   -> ok_feedback passes through a 2-flop synchronizer (2 cycles of lag)
//   undefined -> ok_feedback is used directly and must be synchronous to clk
module feedback_enable_sequencer #(
   parameter int TIMEOUT   = 200,
   parameter int HOLD_CYC  = 4,
   parameter int COOL_CYC  = 16,
   parameter int MAX_RETRY = 3,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       ok_feedback,
   output logic       enable_feedback,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic [1:0] attempt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_COOL = 2'd3;

   // Terminal counts: the timer runs 0..N-1 inside each timed state.
   localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYC - 1);
   localparam logic [CNT_W-1:0] TIMER_MAX = '1;
   localparam logic [1:0]       LAST_TRY  = 2'(MAX_RETRY);

   logic [1:0]       state_reg,   state_next;
   logic [CNT_W-1:0] timer_reg,   timer_next;
   logic             enable_reg,  enable_next;
   logic             busy_reg,    busy_next;
   logic             done_reg,    done_next;
   logic             fail_reg,    fail_next;
   logic [1:0]       attempt_reg, attempt_next;
   logic             ok_s;

`ifdef FBSEQ_OK_SYNC_EN
   logic [1:0] ok_sync_reg;

   // Two-flop synchronizer for the possibly asynchronous ok level.
   always_ff @(posedge clk) begin
      if (rst) begin
         ok_sync_reg <= 2'b00;
      end else begin
         ok_sync_reg <= {ok_sync_reg[0], ok_feedback};
      end
   end

   assign ok_s = ok_sync_reg[1];
`else
   assign ok_s = ok_feedback;
`endif

   // Next-state logic: abort overrides everything; timers clear on every state change.
   always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg;
      enable_next  = enable_reg;
      attempt_next = attempt_reg;
      done_next    = 1'b0;
      fail_next    = 1'b0;

      if (abort) begin
         state_next  = S_IDLE;
         timer_next  = '0;
         enable_next = 1'b0;
         fail_next   = (state_reg != S_IDLE);
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_next   = S_ARM;
                  timer_next   = '0;
                  enable_next  = 1'b1;
                  attempt_next = 2'd0;
               end
            end
            S_ARM: begin
               if (ok_s) begin
                  // ok beats a simultaneous timeout
                  state_next = S_HOLD;
                  timer_next = '0;
               end else if (timer_reg == ARM_LAST) begin
                  timer_next  = '0;
                  enable_next = 1'b0;
                  if (attempt_reg < LAST_TRY) begin
                     state_next = S_COOL;
                  end else begin
                     state_next = S_IDLE;
                     fail_next  = 1'b1;
                  end
               end else if (timer_reg != TIMER_MAX) begin
                  timer_next = timer_reg + 1'b1;
               end
            end
            S_HOLD: begin
               // ok_s is deliberately ignored here; a late drop does not abort the hold
               if (timer_reg == HOLD_LAST) begin
                  state_next  = S_IDLE;
                  timer_next  = '0;
                  enable_next = 1'b0;
                  done_next   = 1'b1;
               end else if (timer_reg != TIMER_MAX) begin
                  timer_next = timer_reg + 1'b1;
               end
            end
            default: begin
               // S_COOL
               if (timer_reg == COOL_LAST) begin
                  state_next   = S_ARM;
                  timer_next   = '0;
                  enable_next  = 1'b1;
                  attempt_next = attempt_reg + 2'd1;
               end else if (timer_reg != TIMER_MAX) begin
                  timer_next = timer_reg + 1'b1;
               end
            end
         endcase
      end

      busy_next = (state_next != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         timer_reg   <= '0;
         enable_reg  <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         fail_reg    <= 1'b0;
         attempt_reg <= 2'd0;
      end else begin
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         enable_reg  <= enable_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         fail_reg    <= fail_next;
         attempt_reg <= attempt_next;
      end
   end

   assign enable_feedback = enable_reg;
   assign busy            = busy_reg;
   assign done            = done_reg;
   assign fail            = fail_reg;
   assign attempt         = attempt_reg;

endmodule

// File: tb/tb_feedback_enable_sequencer.sv
// Testbench for feedback_enable_sequencer.
// Expected done/fail pulses (kind, cycle, attempt) are queued when the stimulus
// is driven. A negedge monitor pops and compares them as the DUT pulses.
// Level checks on enable/busy/attempt are made 1 time unit after the clock edge.
// Latencies follow FBSEQ_OK_SYNC_EN (sync adds 2 cycles).
module tb_feedback_enable_sequencer;

   localparam int TIMEOUT = 200;
   localparam int HOLD    = 4;
   localparam int COOL    = 16;
`ifdef FBSEQ_OK_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   localparam int WIN = TIMEOUT + COOL;   // spacing of ARM windows

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       ok_feedback = 1'b0;
   logic       enable_feedback, busy, done, fail;
   logic [1:0] attempt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int base     = 0;

   typedef struct {
      int kind;   // 1 = done, 2 = fail
      int cyc;
      int att;
   } ev_t;
   ev_t sb_q[$];

   feedback_enable_sequencer #(
      .TIMEOUT(TIMEOUT), .HOLD_CYC(HOLD), .COOL_CYC(COOL), .MAX_RETRY(3), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ok_feedback(ok_feedback),
      .enable_feedback(enable_feedback), .busy(busy), .done(done), .fail(fail),
      .attempt(attempt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc - base);
      end
   endtask

   // Advance to relative cycle k of the current test, 1 time unit after its edge.
   task automatic goto(input int k);
      while (cyc < base + k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic new_test();
      @(posedge clk);
      #1;
      base = cyc;
   endtask

   task automatic push(input int kind, input int k, input int att);
      ev_t e;
      e.kind = kind;
      e.cyc  = base + k;
      e.att  = att;
      sb_q.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Scoreboard monitor: every done/fail pulse must match the head of the queue.
   always @(negedge clk) begin
      if (!rst && (done || fail)) begin
         if (done && fail) begin
            chk("done_fail_excl", 1, 0);
         end
         if (sb_q.size() == 0) begin
            chk("unexpected_pulse", done ? 1 : 2, 0);
         end else begin
            ev_t e;
            e = sb_q.pop_front();
            chk("ev_kind", done ? 1 : 2, e.kind);
            chk("ev_cycle", cyc - base, e.cyc - base);
            chk("ev_attempt", int'(attempt), e.att);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      chk("rst_enable", int'(enable_feedback), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_attempt", int'(attempt), 0);
      chk("rst_done_fail", int'(done | fail), 0);
      rst = 1'b0;

      // ---------------- 1: happy path ----------------
      new_test();
      push(1, 55 + LAT, 0);
      pulse_start();
      chk("t1_en_c1", int'(enable_feedback), 1);
      chk("t1_busy_c1", int'(busy), 1);
      chk("t1_att_c1", int'(attempt), 0);
      goto(50); ok_feedback = 1'b1;
      goto(54 + LAT);
      chk("t1_en_hold", int'(enable_feedback), 1);
      goto(55 + LAT);
      chk("t1_en_done", int'(enable_feedback), 0);
      chk("t1_busy_done", int'(busy), 0);
      ok_feedback = 1'b0;
      goto(60 + LAT);
      chk("t1_busy_after", int'(busy), 0);
      chk("t1_sb_empty", sb_q.size(), 0);

      // ---------------- 2: no ok, retries exhausted ----------------
      new_test();
      push(2, 1 + 3 * WIN + TIMEOUT, 3);
      pulse_start();
      goto(TIMEOUT);      chk("t2_en_last_arm", int'(enable_feedback), 1);
      goto(TIMEOUT + 1);  chk("t2_en_cool", int'(enable_feedback), 0);
      chk("t2_busy_cool", int'(busy), 1);
      goto(WIN);          chk("t2_en_cool_end", int'(enable_feedback), 0);
      for (int a = 1; a <= 3; a++) begin
         goto(1 + a * WIN);
         chk("t2_en_rearm", int'(enable_feedback), 1);
         chk("t2_attempt", int'(attempt), a);
      end
      goto(3 * WIN + TIMEOUT); chk("t2_en_final_arm", int'(enable_feedback), 1);
      goto(1 + 3 * WIN + TIMEOUT);
      chk("t2_en_fail", int'(enable_feedback), 0);
      chk("t2_busy_fail", int'(busy), 0);
      goto(5 + 3 * WIN + TIMEOUT);
      chk("t2_att_held", int'(attempt), 3);
      chk("t2_sb_empty", sb_q.size(), 0);

      // ---------------- 3: success on retry ----------------
      new_test();
      push(1, 235 + LAT, 1);
      pulse_start();
      goto(220); chk("t3_attempt", int'(attempt), 1);
      goto(230); ok_feedback = 1'b1;
      goto(235 + LAT);
      chk("t3_en_done", int'(enable_feedback), 0);
      ok_feedback = 1'b0;
      goto(240 + LAT);
      chk("t3_sb_empty", sb_q.size(), 0);

      // ---------------- 4a: abort mid-HOLD ----------------
      new_test();
      push(2, 8 + LAT, 0);
      pulse_start();
      goto(5); ok_feedback = 1'b1;
      goto(7 + LAT); abort = 1'b1;
      goto(8 + LAT); abort = 1'b0;
      chk("t4a_en", int'(enable_feedback), 0);
      chk("t4a_busy", int'(busy), 0);
      ok_feedback = 1'b0;
      goto(20);
      chk("t4a_sb_empty", sb_q.size(), 0);

      // ---------------- 4b: abort in COOL ----------------
      new_test();
      push(2, 206, 0);
      pulse_start();
      goto(205); abort = 1'b1;
      chk("t4b_en_cool", int'(enable_feedback), 0);
      goto(206); abort = 1'b0;
      chk("t4b_busy", int'(busy), 0);
      goto(212); chk("t4b_en_idle", int'(enable_feedback), 0);
      chk("t4b_sb_empty", sb_q.size(), 0);

      // ---------------- 4c: abort + start in IDLE ----------------
      new_test();
      start = 1'b1; abort = 1'b1;
      goto(1); start = 1'b0; abort = 1'b0;
      chk("t4c_busy", int'(busy), 0);
      chk("t4c_en", int'(enable_feedback), 0);
      goto(10); chk("t4c_busy_later", int'(busy), 0);

      // ---------------- 5: ok on timeout cycle, start during busy ----------------
      new_test();
      push(1, 205, 0);
      pulse_start();
      goto(50);  pulse_start();
      goto(100); pulse_start();
      goto(TIMEOUT - LAT); ok_feedback = 1'b1;
      goto(TIMEOUT - LAT + 1); ok_feedback = 1'b0;
      goto(201); chk("t5_en_hold", int'(enable_feedback), 1);
      chk("t5_att", int'(attempt), 0);
      goto(202); pulse_start();
      goto(205); chk("t5_en_done", int'(enable_feedback), 0);
      goto(215); chk("t5_busy_after", int'(busy), 0);
      chk("t5_sb_empty", sb_q.size(), 0);

      // ---------------- 6: reset in ARM ----------------
      new_test();
      pulse_start();
      goto(20); rst = 1'b1;
      goto(21);
      chk("t6_en", int'(enable_feedback), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_att", int'(attempt), 0);
      chk("t6_done_fail", int'(done | fail), 0);
      rst = 1'b0;
      goto(30);
      chk("t6_busy_after", int'(busy), 0);
      chk("t6_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
